// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

   // Controller states: collecting coins, dispensing, paying out change.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } vend_state_e;

   // Coin values fit in 5 bits (largest is a quarter).
   localparam int COIN_W = 5;

   localparam logic [COIN_W-1:0] NICKEL  = 5'd5;
   localparam logic [COIN_W-1:0] DIME    = 5'd10;
   localparam logic [COIN_W-1:0] QUARTER = 5'd25;

   // Change is always returned as nickels.
   localparam int CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_if.sv
// Coin/button inputs and dispenser/display outputs of the vending controller.
interface vend_if #(
   parameter int CREDIT_W = 7
);
   logic                nb;
   logic                db;
   logic                qb;
   logic                cancel;
   logic                vend;
   logic                chg_nickel;
   logic                coin_rej;
   logic                busy;
   logic [CREDIT_W-1:0] credit;

   // Coin mechanism / front panel side.
   modport master (
      output nb, db, qb, cancel,
      input  vend, chg_nickel, coin_rej, busy, credit
   );

   // Controller side.
   modport slave (
      input  nb, db, qb, cancel,
      output vend, chg_nickel, coin_rej, busy, credit
   );
endinterface

// File: rtl/vend_coin_sel.sv
// Picks one coin per cycle (quarter > dime > nickel) and flags the losers.
module vend_coin_sel
   import vend_pkg::*;
(
   input  logic              nb,
   input  logic              db,
   input  logic              qb,
   output logic              vld,
   output logic [COIN_W-1:0] value,
   output logic              rej
);

   // Priority select; any coin that loses arbitration must be handed back.
   always_comb begin
      vld   = nb | db | qb;
      value = '0;
      rej   = 1'b0;
      if (qb) begin
         value = QUARTER;
         rej   = db | nb;
      end else if (db) begin
         value = DIME;
         rej   = nb;
      end else if (nb) begin
         value = NICKEL;
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates credit, vends at PRICE, pays change as
// paced nickel pulses, and handles cancel/refund.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE    = 25,
   parameter int CREDIT_W = 7,
   parameter int CHG_GAP  = 4
) (
   input  logic  clk,
   input  logic  rst,
   vend_if.slave bus
);

   localparam int GAP_W = (CHG_GAP > 1) ? $clog2(CHG_GAP) : 1;
   localparam logic [GAP_W-1:0]    GAP_RELOAD = GAP_W'(CHG_GAP - 1);
   localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] UNIT_C     = CREDIT_W'(CHANGE_UNIT);

   vend_state_e         state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [GAP_W-1:0]    gap_q;
   logic                coin_rej_q;

   logic                coin_vld;
   logic                coin_lose;
   logic [COIN_W-1:0]   coin_val;
   logic                coin_any;
   logic                cancel_ok;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W-1:0] after_price;
   logic [CREDIT_W-1:0] after_unit;

   vend_coin_sel u_sel (
      .nb    (bus.nb),
      .db    (bus.db),
      .qb    (bus.qb),
      .vld   (coin_vld),
      .value (coin_val),
      .rej   (coin_lose)
   );

   // Datapath helpers; subtractions clamp at zero so credit never wraps.
   always_comb begin
      coin_any    = bus.nb | bus.db | bus.qb;
      cancel_ok   = bus.cancel && (credit_q != '0);
      sum         = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
      after_price = (credit_q > PRICE_C) ? (credit_q - PRICE_C) : '0;
      after_unit  = (credit_q > UNIT_C)  ? (credit_q - UNIT_C)  : '0;
   end

   // Main FSM: state, credit, change pacing counter and coin reject flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         gap_q      <= '0;
         coin_rej_q <= 1'b0;
      end else begin
         coin_rej_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cancel_ok) begin
                  // Refund wins over any coin in the same cycle.
                  coin_rej_q <= coin_any;
                  gap_q      <= '0;
                  state_q    <= CHANGE;
               end else begin
                  coin_rej_q <= coin_lose;
                  if (coin_vld) begin
                     credit_q <= sum[CREDIT_W-1:0];
                     if (sum >= (CREDIT_W+1)'(PRICE))
                        state_q <= VEND;
                  end
               end
            end
            VEND: begin
               coin_rej_q <= coin_any;
               credit_q   <= after_price;
               gap_q      <= '0;
               state_q    <= (after_price != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
               coin_rej_q <= coin_any;
               if (gap_q == '0) begin
                  // This cycle is a nickel pulse.
                  credit_q <= after_unit;
                  if (after_unit == '0) begin
                     gap_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     gap_q   <= GAP_RELOAD;
                  end
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               gap_q   <= '0;
            end
         endcase
      end
   end

   // Outputs decoded from registered state.
   assign bus.vend       = (state_q == VEND);
   assign bus.chg_nickel = (state_q == CHANGE) && (gap_q == '0);
   assign bus.busy       = (state_q != IDLE);
   assign bus.coin_rej   = coin_rej_q;
   assign bus.credit     = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (PRICE=25, CHG_GAP=4).
module tb_vend_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   vend_cnt;
   int   chg_cnt;

   vend_if #(.CREDIT_W(7)) bus ();

   vend_ctrl #(.PRICE(25), .CREDIT_W(7), .CHG_GAP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.vend === 1'b1)       vend_cnt++;
      if (bus.chg_nickel === 1'b1) chg_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present inputs for one edge, then drop them; returns 1ns after the edge.
   task automatic step(input logic n, input logic d, input logic q, input logic c);
      bus.nb = n; bus.db = d; bus.qb = q; bus.cancel = c;
      tick();
      bus.nb = 1'b0; bus.db = 1'b0; bus.qb = 1'b0; bus.cancel = 1'b0;
   endtask

   task automatic outs(input string tag, input int v, input int c, input int r,
                       input int b, input int cr);
      chk({tag, ".vend"},   bus.vend,       v);
      chk({tag, ".chg"},    bus.chg_nickel, c);
      chk({tag, ".rej"},    bus.coin_rej,   r);
      chk({tag, ".busy"},   bus.busy,       b);
      chk({tag, ".credit"}, bus.credit,     cr);
   endtask

   initial begin
      checks = 0; errors = 0; vend_cnt = 0; chg_cnt = 0;
      bus.nb = 1'b0; bus.db = 1'b0; bus.qb = 1'b0; bus.cancel = 1'b0;
      rst = 1'b1;

      // Reset state
      tick(); tick();
      outs("rst", 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b0;
      tick();
      outs("rst_rel", 0, 0, 0, 0, 0);

      // Five nickels, 3 cycles apart
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, 0, 0);
         chk("nb.credit", bus.credit, i * 5);
         chk("nb.vend", bus.vend, 0);
         tick(); tick();
      end
      chg_cnt = 0;
      step(1, 0, 0, 0);
      outs("nb5", 1, 0, 0, 1, 25);
      tick();
      outs("nb5_post", 0, 0, 0, 0, 0);
      tick();
      chk("nb5.no_chg", chg_cnt, 0);

      // Three dimes -> 30, one nickel back
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("dd.credit", bus.credit, 20);
      step(0, 1, 0, 0);
      outs("ddd", 1, 0, 0, 1, 30);
      tick();
      outs("ddd_chg", 0, 1, 0, 1, 5);
      // coin on the edge ending the final pulse is still rejected
      step(1, 0, 0, 0);
      outs("ddd_end", 0, 0, 1, 0, 0);
      step(1, 0, 0, 0);
      outs("idle_acc", 0, 0, 0, 0, 5);

      // Async reset clears credit 15 without a clock edge
      step(0, 1, 0, 0);
      chk("pre_rst.credit", bus.credit, 15);
      #2 rst = 1'b1;
      #1;
      chk("async_rst.credit", bus.credit, 0);
      @(negedge clk); rst = 1'b0;
      tick();

      // Dime + quarter -> 35, two nickels 4 cycles apart
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      outs("dq", 1, 0, 0, 1, 35);
      tick();
      outs("dq_chg1", 0, 1, 0, 1, 10);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dq_gap.chg", bus.chg_nickel, 0);
      end
      tick();
      outs("dq_chg2", 0, 1, 0, 1, 5);
      tick();
      outs("dq_done", 0, 0, 0, 0, 0);

      // Dime then cancel; nickel during CHANGE rejected
      vend_cnt = 0;
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      outs("cx_chg1", 0, 1, 0, 1, 10);
      step(1, 0, 0, 0);
      outs("cx_rej", 0, 0, 1, 1, 5);
      tick();
      chk("cx_rej_off", bus.coin_rej, 0);
      tick();
      tick();
      outs("cx_chg2", 0, 1, 0, 1, 5);
      tick();
      outs("cx_done", 0, 0, 0, 0, 0);
      chk("cx.no_vend", vend_cnt, 0);

      // Cancel at credit 0 ignored, coin still taken
      step(1, 0, 0, 1);
      outs("cx0", 0, 0, 0, 0, 5);
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      tick(); tick(); tick();
      chk("cx0_clean.credit", bus.credit, 0);

      // Nickel + quarter together from 0
      step(1, 0, 1, 0);
      outs("nq", 1, 0, 1, 1, 25);
      tick();
      outs("nq_post", 0, 0, 0, 0, 0);

      // Cancel with a dime at credit 10: refund 10, dime rejected
      step(0, 1, 0, 0);
      chk("cd_pre.credit", bus.credit, 10);
      step(0, 1, 0, 1);
      outs("cd", 0, 1, 1, 1, 10);
      tick();
      outs("cd_gap", 0, 0, 0, 1, 5);
      tick(); tick(); tick();
      outs("cd_chg2", 0, 1, 0, 1, 5);
      tick();
      outs("cd_done", 0, 0, 0, 0, 0);

      // Reset during CHANGE: change is lost
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      tick();
      chk("mid_chg", bus.chg_nickel, 1);
      #2 rst = 1'b1;
      #1;
      vend_cnt = 0; chg_cnt = 0;
      outs("mid_rst", 0, 0, 0, 0, 0);
      repeat (8) tick();
      chk("mid_rst.chg_cnt", chg_cnt, 0);
      chk("mid_rst.vend_cnt", vend_cnt, 0);
      @(negedge clk); rst = 1'b0;
      repeat (6) tick();
      chk("post_rst.chg_cnt", chg_cnt, 0);
      chk("post_rst.credit", bus.credit, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised coin-operated vending controller. It accepts nickel, dime and quarter pulses and accumulates credit up to a configurable price. It issues a one-cycle vend pulse, then returns any overpayment as a paced train of nickel-dispense pulses. It also supports cancel/refund and flags coins arriving while the machine cannot accept them. It sits between the pre-debounced coin/button inputs and the dispenser/display logic; `credit` feeds the bin2bcd/7-seg path.

## Interface
- `PRICE`, 25: item price in cents; must be a multiple of 5 and ≥ 5.
- `CREDIT_W`, 7: width of `credit`; must satisfy 2^CREDIT_W > PRICE+20.
- `CHG_GAP`, 4: cycles between successive change pulses; ≥ 1.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `nb` in 1: nickel inserted; single-cycle pulse, already debounced.
- `db` in 1: dime inserted; single-cycle pulse.
- `qb` in 1: quarter inserted; single-cycle pulse.
- `cancel` in 1: refund request; single-cycle pulse.
- `vend` out 1: dispense item; high exactly one cycle per sale.
- `chg_nickel` out 1: return one nickel; one pulse per 5 cents returned.
- `coin_rej` out 1: coin returned to customer; registered, one cycle after the offending edge.
- `busy` out 1: high in VEND and CHANGE.
- `credit` out CREDIT_W: current credit in cents, registered.

## Operation
- States: IDLE, VEND, CHANGE (enum in package).
- Reset values: state=IDLE, credit=0, gap counter=0, `vend`=`chg_nickel`=`coin_rej`=`busy`=0.
- IDLE, coin selection: if several coin inputs are high, priority is qb > db > nb. The selected coin is accepted. Every other high coin input sets `coin_rej` on the next cycle.
- IDLE, accept: sum = credit + coin value, and credit <= sum.
  - If sum ≥ PRICE, go to VEND.
  - Otherwise stay in IDLE.
- IDLE, cancel: `cancel` with credit > 0 has priority over coins. All coins in that cycle are rejected and the state goes to CHANGE.
  - If credit == 0, `cancel` is ignored but coins are still processed.
- VEND: `vend` = 1 (decoded from state).
  - credit <= credit − PRICE.
  - Go to CHANGE if the result is > 0; otherwise go to IDLE.
- CHANGE: `chg_nickel` = 1 when gap counter == 0.
  - On that cycle, credit <= credit − 5 and the gap counter reloads to CHG_GAP−1.
  - Otherwise the gap counter decrements.
  - After the pulse that brings credit to 0, go to IDLE with the gap counter at 0.
- Any coin in VEND or CHANGE is rejected (`coin_rej`) and credit is unchanged. `cancel` is ignored there.
- Credit never exceeds PRICE+20 and never underflows. Subtraction is width-safe at CREDIT_W.

## Timing
- Coin sampled at edge N: `credit` updates at edge N.
  - If the price is reached, `vend` is high for cycle N→N+1 and low after.
- First `chg_nickel` occurs in the first CHANGE cycle, i.e. the cycle immediately after the `vend` cycle.
  - Later pulses are spaced exactly CHG_GAP cycles apart.
- Cancel at edge N with credit > 0: first `chg_nickel` in cycle N→N+1.
- Return to IDLE: the first coin accepted is the one sampled at the edge after the final `chg_nickel` cycle.
- `rst` asserted mid-operation: all registers clear immediately. No further `vend` or `chg_nickel` pulses; in-flight change is lost.
- `coin_rej` asserts the cycle after the rejected coin's edge, for one cycle per rejecting edge.

## Structure
- Package `vend_pkg`:
  - state enum (IDLE, VEND, CHANGE);
  - coin value constants NICKEL=5, DIME=10, QUARTER=25;
  - CHANGE_UNIT=5.
- Sub-module `vend_coin_sel` (combinational): takes nb/db/qb; outputs valid, coin value, and a reject flag for non-selected coins.
- Top level: state register, credit register, gap counter, output decode.

## Test plan
Defaults PRICE=25, CHG_GAP=4.
- Reset with all inputs low: all outputs 0 and credit = 0. Pulsing `rst` later clears credit = 15 back to 0 without waiting for `clk`.
- Five nb pulses, each 3 cycles apart: credit 5/10/15/20, then `vend` one cycle after the fifth coin. No `chg_nickel`; credit = 0; back in IDLE.
- db, db, db: credit reaches 30, then `vend`. One `chg_nickel` in the next cycle, then credit = 0 and IDLE.
- db then qb: credit 35, then `vend`. `chg_nickel` in the next cycle and again exactly 4 cycles later; credit 5 then 0.
- db then `cancel`: two `chg_nickel` pulses 4 cycles apart and no `vend`. An nb during CHANGE gives `coin_rej` one cycle later and credit is unaffected.
- nb and qb in the same cycle from credit 0: credit = 25, then `vend`. `coin_rej` pulses once. A `cancel` together with db at credit 10 gives refund of 10 and `coin_rej`.
